// File: rtl/uno_pkg.sv
`default_nettype none
// =============================================================================
// Module  : uno_pkg
// Brief   : Shared types and constants for the Uno serial link (TX and RX).
//           Bits per byte follow the PARITY_EN build option.
// Revision: 1.0  initial release
// =============================================================================
package uno_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SHIFT    = 2'd2
    } unoState_t;

    localparam int UNO_CLKDIV_DEFAULT = 25;
    localparam int UNO_DATA_BITS      = 8;
`ifdef PARITY_EN
    localparam int UNO_BITS_PER_BYTE  = UNO_DATA_BITS + 1;
`else
    localparam int UNO_BITS_PER_BYTE  = UNO_DATA_BITS;
`endif

endpackage
`default_nettype wire

// File: rtl/uno_clk_gen.sv
`default_nettype none
// =============================================================================
// Module  : uno_clk_gen
// Brief   : Free-running divider producing unoClk plus registered one-clk
//           strobes on its rising and falling transitions.
// Revision: 1.0  initial release
// =============================================================================
module uno_clk_gen
    import uno_pkg::*;
#(
    parameter int ClkDiv = UNO_CLKDIV_DEFAULT
) (
    input  logic clk,
    input  logic Reset,
    output logic unoClk,
    output logic riseStrobe,
    output logic fallStrobe
);

    localparam int              c_cntW   = $clog2(ClkDiv);
    localparam logic [c_cntW-1:0] c_cntMax = c_cntW'(ClkDiv - 1);

    logic [c_cntW-1:0] r_cnt;
    logic              r_unoClk;
    logic              r_rise;
    logic              r_fall;

    // Strobes are registered alongside the toggle so they coincide with the new level.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_unoClk <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_cnt == c_cntMax) begin
                r_cnt    <= '0;
                r_unoClk <= ~r_unoClk;
                r_rise   <= ~r_unoClk;
                r_fall   <= r_unoClk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign unoClk     = r_unoClk;
    assign riseStrobe = r_rise;
    assign fallStrobe = r_fall;

endmodule
`default_nettype wire

// File: rtl/uno_image_tx.sv
`default_nettype none
// =============================================================================
// Module  : uno_image_tx
// Brief   : Bit-serial MSB-first image transmitter to the Arduino Uno.
//           Build option PARITY_EN appends an even-parity bit to every byte.
// Revision: 1.0  initial release
// =============================================================================
module uno_image_tx
    import uno_pkg::*;
#(
    parameter int MaxImageBytes = 160,
    parameter int ClkDiv        = UNO_CLKDIV_DEFAULT
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        StartFlag,
    input  logic [15:0] ByteCount,
    output logic [15:0] MemAddress,
    input  logic [7:0]  InternalMemOut,
    output logic        unoClk,
    output logic        SerialOut,
    output logic        FrameOut,
    output logic        Busy,
    output logic        DoneFlag
);

    localparam logic [15:0] c_maxBytes = 16'(MaxImageBytes);
    localparam logic [3:0]  c_lastBit  = 4'(UNO_BITS_PER_BYTE - 1);

    logic        w_riseStrobe;
    logic        w_fallStrobe;
    logic [15:0] w_clampN;

    unoState_t   r_state;
    logic [15:0] r_n;
    logic [15:0] r_byteIdx;
    logic [3:0]  r_bitCnt;
    logic [7:0]  r_shreg;
    logic [7:0]  r_hold;
    logic        r_prefetchWait;
    logic        r_finish;
    logic        r_serial;
    logic        r_frame;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_addr;
`ifdef PARITY_EN
    logic        r_parity;
`endif

    uno_clk_gen #(
        .ClkDiv(ClkDiv)
    ) u_clkGen (
        .clk       (clk),
        .Reset     (Reset),
        .unoClk    (unoClk),
        .riseStrobe(w_riseStrobe),
        .fallStrobe(w_fallStrobe)
    );

    assign w_clampN = (ByteCount > c_maxBytes) ? c_maxBytes : ByteCount;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_n            <= '0;
            r_byteIdx      <= '0;
            r_bitCnt       <= '0;
            r_shreg        <= '0;
            r_hold         <= '0;
            r_prefetchWait <= 1'b0;
            r_finish       <= 1'b0;
            r_serial       <= 1'b0;
            r_frame        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_addr         <= '0;
`ifdef PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (StartFlag) begin
                        r_addr <= '0;
                        if (w_clampN == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_n            <= w_clampN;
                            r_busy         <= 1'b1;
                            r_prefetchWait <= 1'b0;
                            r_state        <= PREFETCH;
                        end
                    end
                end
                PREFETCH: begin
                    // Address 0 has been stable a full clk before the capture edge.
                    if (!r_prefetchWait) begin
                        r_prefetchWait <= 1'b1;
                    end else begin
                        r_hold    <= InternalMemOut;
                        r_addr    <= (r_n > 16'd1) ? 16'd1 : 16'd0;
                        r_bitCnt  <= '0;
                        r_byteIdx <= '0;
                        r_finish  <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Next byte is fetched mid-way through the first bit of the current one.
                    if (w_riseStrobe && r_bitCnt == 4'd1 && (r_byteIdx + 16'd1) < r_n) begin
                        r_hold <= InternalMemOut;
                        if (r_addr < r_n - 16'd1) begin
                            r_addr <= r_addr + 16'd1;
                        end
                    end
                    if (w_fallStrobe) begin
                        if (r_finish) begin
                            r_serial <= 1'b0;
                            r_frame  <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_addr   <= '0;
                            r_finish <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_frame <= 1'b1;
                            if (r_bitCnt == 4'd0) begin
                                r_serial <= r_hold[7];
                                r_shreg  <= {r_hold[6:0], 1'b0};
`ifdef PARITY_EN
                                r_parity <= ^r_hold;
`endif
                            end
`ifdef PARITY_EN
                            else if (r_bitCnt == 4'(UNO_DATA_BITS)) begin
                                r_serial <= r_parity;
                            end
`endif
                            else begin
                                r_serial <= r_shreg[7];
                                r_shreg  <= {r_shreg[6:0], 1'b0};
                            end
                            if (r_bitCnt == c_lastBit) begin
                                r_bitCnt <= '0;
                                if (r_byteIdx == r_n - 16'd1) begin
                                    r_finish <= 1'b1;
                                end else begin
                                    r_byteIdx <= r_byteIdx + 16'd1;
                                end
                            end else begin
                                r_bitCnt <= r_bitCnt + 4'd1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MemAddress = r_addr;
    assign SerialOut  = r_serial;
    assign FrameOut   = r_frame;
    assign Busy       = r_busy;
    assign DoneFlag   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uno_image_tx.sv
`default_nettype none
// =============================================================================
// Module  : tb_uno_image_tx
// Brief   : Self-checking bench for uno_image_tx against a bit-queue model.
// Revision: 1.0  initial release
// =============================================================================
module tb_uno_image_tx;

`ifdef PARITY_EN
    localparam int B = 9;
`else
    localparam int B = 8;
`endif
    localparam int MAXB = 160;

    logic        clk = 1'b0;
    logic        Reset;
    logic        StartFlag;
    logic [15:0] ByteCount;
    logic [15:0] MemAddress;
    logic [7:0]  InternalMemOut;
    logic        unoClk;
    logic        SerialOut;
    logic        FrameOut;
    logic        Busy;
    logic        DoneFlag;

    logic [7:0]  mem [0:255];

    int          checks = 0;
    int          errors = 0;
    bit          expQ[$];
    int          bitsSeen = 0;
    int          doneCount = 0;
    int          bitsBase;
    int          doneBase;
    int          curN = 0;
    logic        prevUno = 1'b0;
    logic        prevDone = 1'b0;
    logic [63:0] gotBits = '0;

    uno_image_tx #(
        .MaxImageBytes(MAXB),
        .ClkDiv       (4)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .StartFlag     (StartFlag),
        .ByteCount     (ByteCount),
        .MemAddress    (MemAddress),
        .InternalMemOut(InternalMemOut),
        .unoClk        (unoClk),
        .SerialOut     (SerialOut),
        .FrameOut      (FrameOut),
        .Busy          (Busy),
        .DoneFlag      (DoneFlag)
    );

    always #5 clk = ~clk;

    // Synchronous-read image memory: data follows the address by one clk.
    always @(posedge clk)
        InternalMemOut <= (MemAddress < 16'd256) ? mem[MemAddress[7:0]] : 8'h00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // One clk step; the Uno-side view is checked at every rising unoClk.
    task automatic tick();
        bit e;
        @(negedge clk);
        if (Reset) begin
            prevUno  = 1'b0;
            prevDone = 1'b0;
        end else begin
            if (unoClk && !prevUno) begin
                if (FrameOut) begin
                    bitsSeen++;
                    gotBits = {gotBits[62:0], SerialOut};
                    if (expQ.size() == 0) begin
                        check("extra_bit", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("serial_bit", 64'(SerialOut), 64'(e));
                    end
                end else begin
                    check("idle_line", 64'(SerialOut), 64'd0);
                end
            end
            if (Busy && curN > 0)
                check("addr_bound", 64'(MemAddress < 16'(curN)), 64'd1);
            if (DoneFlag) begin
                doneCount++;
                check("done_width", 64'(prevDone), 64'd0);
            end
            prevUno  = unoClk;
            prevDone = DoneFlag;
        end
    endtask

    task automatic start_frame(input int n);
        int nn;
        logic [7:0] d;
        nn = (n > MAXB) ? MAXB : n;
        expQ.delete();
        for (int i = 0; i < nn; i++) begin
            d = mem[i];
            for (int j = 7; j >= 0; j--) expQ.push_back(d[j]);
`ifdef PARITY_EN
            expQ.push_back(^d);
`endif
        end
        gotBits   = '0;
        bitsBase  = bitsSeen;
        doneBase  = doneCount;
        curN      = nn;
        ByteCount = 16'(n);
        StartFlag = 1'b1;
        tick();
        StartFlag = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit pulseMid);
        int k;
        k = 0;
        while (doneCount == doneBase && k < budget) begin
            StartFlag = pulseMid && Busy && (k % 300 == 150);
            tick();
            k++;
        end
        StartFlag = 1'b0;
        check("done_timeout", 64'(doneCount > doneBase), 64'd1);
        check("bit_count", 64'(bitsSeen - bitsBase), 64'(B * curN));
        check("queue_empty", 64'(expQ.size()), 64'd0);
        tick();
        check("done_low_after", 64'(DoneFlag), 64'd0);
        check("busy_low_after", 64'(Busy), 64'd0);
        check("frame_low_after", 64'(FrameOut), 64'd0);
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        logic [63:0] lit;
        int          nb;
        int          k;

        Reset     = 1'b1;
        StartFlag = 1'b1;
        ByteCount = 16'd1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) tick();
        check("rst_unoClk", 64'(unoClk), 64'd0);
        check("rst_serial", 64'(SerialOut), 64'd0);
        check("rst_frame", 64'(FrameOut), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(DoneFlag), 64'd0);
        check("rst_addr", 64'(MemAddress), 64'd0);
        StartFlag = 1'b0;
        Reset     = 1'b0;
        repeat (5) tick();

        // Single byte A5
        mem[0] = 8'hA5;
        start_frame(1);
        wait_done(400, 1'b0);
`ifdef PARITY_EN
        lit = 64'h14A; nb = 9;
`else
        lit = 64'hA5;  nb = 8;
`endif
        check("lit_A5", gotBits & ((64'd1 << nb) - 64'd1), lit);

        // Three bytes contiguous
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
        start_frame(3);
        wait_done(1000, 1'b0);
`ifdef PARITY_EN
        lit = 64'({8'h01, 1'b1, 8'h80, 1'b1, 8'hFF, 1'b0}); nb = 27;
`else
        lit = 64'h0180FF; nb = 24;
`endif
        check("lit_3byte", gotBits & ((64'd1 << nb) - 64'd1), lit);

        // Parity-sensitive patterns
        mem[0] = 8'h07;
        start_frame(1);
        wait_done(400, 1'b0);
`ifdef PARITY_EN
        lit = 64'h00F; nb = 9;
`else
        lit = 64'h07;  nb = 8;
`endif
        check("lit_07", gotBits & ((64'd1 << nb) - 64'd1), lit);
        mem[0] = 8'h03;
        start_frame(1);
        wait_done(400, 1'b0);
`ifdef PARITY_EN
        lit = 64'h006; nb = 9;
`else
        lit = 64'h03;  nb = 8;
`endif
        check("lit_03", gotBits & ((64'd1 << nb) - 64'd1), lit);

        // Zero-length request
        start_frame(0);
        check("zero_done", 64'(DoneFlag), 64'd1);
        check("zero_busy", 64'(Busy), 64'd0);
        tick();
        check("zero_done_pulse", 64'(DoneFlag), 64'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("zero_no_frame", 64'(FrameOut), 64'd0);
        end
        check("zero_bits", 64'(bitsSeen - bitsBase), 64'd0);

        // Random short frames
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            start_frame(int'($urandom_range(1, 6)));
            wait_done(2000, 1'b0);
        end

        // Oversized request, clamped, with StartFlag pulses mid-frame
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        start_frame(200);
        wait_done(20000, 1'b1);

        // Reset in the middle of byte 1
        start_frame(5);
        k = 0;
        while ((bitsSeen - bitsBase) < B + 3 && k < 2000) begin
            tick();
            k++;
        end
        check("reach_byte1", 64'((bitsSeen - bitsBase) >= B + 3), 64'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("abort_unoClk", 64'(unoClk), 64'd0);
        check("abort_serial", 64'(SerialOut), 64'd0);
        check("abort_frame", 64'(FrameOut), 64'd0);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(DoneFlag), 64'd0);
        check("abort_addr", 64'(MemAddress), 64'd0);
        repeat (3) tick();
        Reset = 1'b0;
        expQ.delete();
        curN = 0;
        for (int i = 0; i < 30; i++) tick();
        check("abort_no_done", 64'(doneCount - doneBase), 64'd0);
        mem[0] = 8'h3C; mem[1] = 8'hC3;
        start_frame(2);
        wait_done(2000, 1'b0);
`ifdef PARITY_EN
        lit = 64'({8'h3C, 1'b0, 8'hC3, 1'b0}); nb = 18;
`else
        lit = 64'h3CC3; nb = 16;
`endif
        check("restart_byte0", gotBits & ((64'd1 << nb) - 64'd1), lit);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
